pipelined_addsub: RTL and testbench

Parametrised, pipelined N-bit adder/subtractor. It is the successor to the team's 4-bit ripple-borrow subtractor. The carry/borrow chain is split into STAGES register-separated slices so wide operands close timing. A per-transaction mode selects A+B+cin or A-B-bin. Valid/ready handshakes on both sides let it sit directly in the datapath between streaming producers and consumers.

---
 rtl/addsub_pkg.sv | 8 +
 rtl/addsub_slice.sv | 24 ++
 rtl/pipelined_addsub.sv | 108 ++++++++++
 tb/tb_pipelined_addsub.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: mode encodings and the signed-overflow equation shared by the adder/subtractor
package addsub_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  function automatic logic ovf_flag(input logic sub, input logic a_msb, input logic b_msb, input logic r_msb);
    return ((sub == MODE_SUB) ? (a_msb != b_msb) : (a_msb == b_msb)) && (r_msb != a_msb);
  endfunction
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: combinational CHUNK-bit add/sub ripple; sub selects mode, ci/co are carry or borrow
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic             sub,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  logic [CHUNK:0] c;
  always_comb begin
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = a[i] ^ b[i] ^ c[i];
      c[i+1] = (sub == MODE_ADD) ? ((a[i] & b[i]) | (c[i] & (a[i] ^ b[i])))
                                 : ((~a[i] & b[i]) | (c[i] & ~a[i]) | (c[i] & b[i]));
    end
    co = c[CHUNK];
  end
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep add/sub, CHUNK bits per stage; valid/ready in (in_*) and out (out_*), global stall
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cb,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cb,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int CHUNK = WIDTH / STAGES;
  logic adv;
  logic ovf_q, ovf_d, zero_q, zero_d;
  assign adv = ~out_valid | out_ready;
  assign in_ready = adv;
  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_st
    // operands shrink and results grow by one chunk per stage
    localparam int AW = WIDTH - k * CHUNK;
    localparam int RW = (k + 1) * CHUNK;
    logic v_i, c_i, s_i;
    logic [AW-1:0] a_i, b_i;
    logic [CHUNK-1:0] sum;
    logic co, v_q, v_d, c_q, c_d;
    logic [RW-1:0] r_q, r_d;
    if (k == 0) begin : g_src
      assign {v_i, c_i, s_i, a_i, b_i} = {in_valid, in_cb, in_sub, in_a, in_b};
      always_comb r_d = sum;
    end else begin : g_src
      assign {v_i, c_i, s_i, a_i, b_i} = {g_st[k-1].v_q, g_st[k-1].c_q, g_st[k-1].g_op.s_q,
                                          g_st[k-1].g_op.a_q, g_st[k-1].g_op.b_q};
      always_comb r_d = {sum, g_st[k-1].r_q};
    end
    addsub_slice #(.CHUNK(CHUNK)) u_slice (
      .sub(s_i),
      .a  (a_i[CHUNK-1:0]),
      .b  (b_i[CHUNK-1:0]),
      .ci (c_i),
      .s  (sum),
      .co (co)
    );
    always_comb begin
      v_d = v_i;
      c_d = co;
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (adv) begin
        v_q <= v_d;
        c_q <= c_d;
        r_q <= r_d;
      end
    // the last stage has nothing left to forward
    if (k < STAGES - 1) begin : g_op
      logic s_q, s_d;
      logic [AW-CHUNK-1:0] a_q, a_d, b_q, b_d;
      always_comb begin
        s_d = s_i;
        a_d = a_i[AW-1:CHUNK];
        b_d = b_i[AW-1:CHUNK];
      end
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          s_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          s_q <= s_d;
          a_q <= a_d;
          b_q <= b_d;
        end
    end
  end
  // the final chunk holds both operand MSBs, so flags come straight from the last stage inputs
  always_comb begin
    ovf_d = ovf_flag(g_st[STAGES-1].s_i, g_st[STAGES-1].a_i[CHUNK-1],
                     g_st[STAGES-1].b_i[CHUNK-1], g_st[STAGES-1].sum[CHUNK-1]);
    zero_d = ~|g_st[STAGES-1].r_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
      zero_q <= zero_d;
    end
  assign out_valid = g_st[STAGES-1].v_q;
  assign out_res = g_st[STAGES-1].r_q;
  assign out_cb = g_st[STAGES-1].c_q;
  assign out_ovf = ovf_q;
  assign out_zero = zero_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: scoreboard bench for the 16-bit/4-stage and 4-bit/1-stage configurations
module tb_pipelined_addsub;
  typedef struct packed {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cb;
    logic [15:0] res;
    logic        co;
    logic        ovf;
    logic        zero;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_ready, in_cb = 1'b0, in_sub = 1'b0;
  logic [15:0] in_a = '0, in_b = '0, out_res;
  logic out_valid, out_ready = 1'b1, out_cb, out_ovf, out_zero;
  logic in4_valid = 1'b0, in4_ready, in4_cb = 1'b0, in4_sub = 1'b1;
  logic [3:0] in4_a = '0, in4_b = '0, out4_res;
  logic out4_valid, out4_ready = 1'b1, out4_cb, out4_ovf, out4_zero;
  int checks = 0, failures = 0, run = 0, max_run = 0, lat;
  logic [18:0] sb[$];
  logic [6:0] sb4[$];
  logic [18:0] e;
  logic [6:0] e4;
  logic [15:0] snap_res;
  logic snap_cb;
  vec_t vecs[14];
  always #5 clk = ~clk;
  pipelined_addsub #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cb(in_cb), .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_cb(out_cb), .out_ovf(out_ovf), .out_zero(out_zero)
  );
  pipelined_addsub #(.WIDTH(4), .STAGES(1)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in4_valid), .in_ready(in4_ready), .in_a(in4_a), .in_b(in4_b),
    .in_cb(in4_cb), .in_sub(in4_sub), .out_valid(out4_valid), .out_ready(out4_ready),
    .out_res(out4_res), .out_cb(out4_cb), .out_ovf(out4_ovf), .out_zero(out4_zero)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic send(input int i);
    logic acc;
    in_valid = 1'b1;
    in_sub = vecs[i].sub;
    in_a = vecs[i].a;
    in_b = vecs[i].b;
    in_cb = vecs[i].cb;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sb.push_back({vecs[i].res, vecs[i].co, vecs[i].ovf, vecs[i].zero});
        return;
      end
    end
    chk("send_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs = '{
      {1'b1, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0},
      {1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0},
      {1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0},
      {1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
      {1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0},
      {1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1},
      {1'b1, 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0},
      {1'b0, 16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0, 1'b0},
      {1'b0, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0},
      {1'b1, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0},
      {1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1},
      {1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0},
      {1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0},
      {1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0}
    };
    fork
      forever begin
        @(negedge clk);
        run = out_valid ? run + 1 : 0;
        if (run > max_run) max_run = run;
        if (!rst && out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%h required=none", out_res);
          end else begin
            e = sb.pop_front();
            chk("res", {16'd0, out_res}, {16'd0, e[18:3]});
            chk("cb", {31'd0, out_cb}, {31'd0, e[2]});
            chk("ovf", {31'd0, out_ovf}, {31'd0, e[1]});
            chk("zero", {31'd0, out_zero}, {31'd0, e[0]});
          end
        end
        if (!rst && out4_valid && out4_ready) begin
          if (sb4.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output4 actual=%h required=none", out4_res);
          end else begin
            e4 = sb4.pop_front();
            chk("res4", {28'd0, out4_res}, {28'd0, e4[6:3]});
            chk("cb4", {31'd0, out4_cb}, {31'd0, e4[2]});
            chk("ovf4", {31'd0, out4_ovf}, {31'd0, e4[1]});
            chk("zero4", {31'd0, out4_zero}, {31'd0, e4[0]});
          end
        end
      end
    join_none
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_res", {16'd0, out_res}, 32'd0);
    chk("rst_flags", {29'd0, out_cb, out_ovf, out_zero}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(0);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 32'd4);
    repeat (6) @(posedge clk);
    #1 max_run = 0;
    for (int i = 1; i <= 8; i++) send(i);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("stream_run", max_run, 32'd8);
    for (int i = 9; i <= 12; i++) send(i);
    in_sub = vecs[13].sub;
    in_a = vecs[13].a;
    in_b = vecs[13].b;
    in_cb = vecs[13].cb;
    out_ready = 1'b0;
    snap_res = out_res;
    snap_cb = out_cb;
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_head", {16'd0, out_res}, {16'd0, vecs[9].res});
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_hold_res", {16'd0, out_res}, {16'd0, snap_res});
      chk("stall_hold_cb", {31'd0, out_cb}, {31'd0, snap_cb});
    end
    out_ready = 1'b1;
    send(13);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i <= 3; i++) send(i);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_res", {16'd0, out_res}, 32'd0);
    chk("midrst_flags", {29'd0, out_cb, out_ovf, out_zero}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("no_stale_valid", {31'd0, out_valid}, 32'd0);
    send(4);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency_after_rst", lat, 32'd4);
    in4_valid = 1'b1;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          int d, sa, sb_, sd;
          logic [3:0] r;
          d = a - b - c;
          r = 4'(d);
          sa = (a >= 8) ? a - 16 : a;
          sb_ = (b >= 8) ? b - 16 : b;
          sd = sa - sb_ - c;
          in4_a = 4'(a);
          in4_b = 4'(b);
          in4_cb = c[0];
          sb4.push_back({r, d < 0, (sd < -8) || (sd > 7), r == 4'd0});
          @(posedge clk);
          #1;
        end
    in4_valid = 1'b0;
    for (int n = 0; n < 20 && (sb.size() != 0 || sb4.size() != 0); n++) @(posedge clk);
    #1 chk("drain", sb.size() + sb4.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
